// File: rtl/seg_scan_sched.sv
// Round-robin time-multiplexer for a shared 7-segment bus: each unmasked digit
// gets a blanking gap, a one-cycle segment snapshot, then a fixed-length dwell.
module seg_scan_sched #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1024,
  parameter int BLANK      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_DIGITS*8-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   skip_mask,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [2:0]              cur_digit,
  output logic                    sample_strobe,
  output logic                    frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_BLANK, S_SHOW} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            last_q, last_d;
  logic [2:0]            cur_q, cur_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  first_q, first_d;

  logic [7:0] seg_arr [8];
  logic [7:0] mask8;
  logic [2:0] pick;
  logic       found;
  logic       all_masked;

  // Pad unused slots as masked so the circular search never lands on them.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_DIGITS) begin : g_real
        assign seg_arr[gi] = seg_in[8*gi +: 8];
        assign mask8[gi]   = skip_mask[gi];
      end else begin : g_none
        assign seg_arr[gi] = 8'h00;
        assign mask8[gi]   = 1'b1;
      end
    end
  endgenerate

  assign all_masked = &skip_mask;

  // Descending scan so the nearest unmasked index after last_shown wins.
  always_comb begin
    int idx;
    pick  = 3'd0;
    found = 1'b0;
    idx   = 0;
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
      if (!mask8[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_d   = cur_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    first_d = first_q;
    if (!enable) begin
      state_d = S_IDLE;
      seg_d   = 8'h00;
      dig_d   = '0;
      first_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!all_masked) state_d = S_SELECT;
        end
        S_SELECT: begin
          if (found) begin
            cur_d   = pick;
            last_d  = pick;
            cnt_d   = CW'(BLANK);
            first_d = 1'b0;
            state_d = S_BLANK;
          end else begin
            first_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BLANK: begin
          if (cnt_q == CW'(1)) begin
            seg_d   = seg_arr[cur_q];
            dig_d   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << cur_q;
            cnt_d   = CW'(DWELL);
            state_d = S_SHOW;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == CW'(1)) begin
            seg_d = 8'h00;
            dig_d = '0;
            if (all_masked) begin
              first_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_SELECT;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 3'(NUM_DIGITS - 1);
      cur_q   <= 3'd0;
      seg_q   <= 8'h00;
      dig_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      first_q <= first_d;
    end
  end

  assign seg_out       = seg_q;
  assign dig_en        = dig_q;
  assign cur_digit     = cur_q;
  assign sample_strobe = enable && (state_q == S_BLANK) && (cnt_q == CW'(1));
  assign frame_done    = enable && (state_q == S_SELECT) && found && !first_q && (pick <= last_q);

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched: a table of expected digit visits plus
// hand-written sequences for disable, all-masked and asynchronous reset.
module tb_seg_scan_sched;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [31:0]   seg_in;
  logic [ND-1:0] skip_mask;
  logic [7:0]    seg_out;
  logic [ND-1:0] dig_en;
  logic [2:0]    cur_digit;
  logic          sample_strobe;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_sched #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .seg_in       (seg_in),
    .skip_mask    (skip_mask),
    .seg_out      (seg_out),
    .dig_en       (dig_en),
    .cur_digit    (cur_digit),
    .sample_strobe(sample_strobe),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [2:0]  dig;
    logic [7:0]  seg;
    logic        fd;
    logic        upd;
    logic [31:0] upd_val;
  } visit_t;

  visit_t vt [21];

  function automatic visit_t mk(input logic [3:0] m, input int d, input logic [7:0] s,
                                input logic fd, input logic upd, input logic [31:0] uv);
    visit_t v;
    v.mask = m; v.dig = 3'(d); v.seg = s; v.fd = fd; v.upd = upd; v.upd_val = uv;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered in the SELECT cycle; returns in the following SELECT cycle.
  task automatic visit(input visit_t v);
    logic [3:0] exp_en;
    exp_en = 4'b0001 << v.dig;
    skip_mask = v.mask;
    #1;
    chk("sel_frame_done", 32'(frame_done), 32'(v.fd));
    chk("sel_dig_en", 32'(dig_en), 32'd0);
    for (int b = 1; b <= BL; b++) begin
      step();
      chk("blank_cur_digit", 32'(cur_digit), 32'(v.dig));
      chk("blank_dig_en", 32'(dig_en), 32'd0);
      chk("blank_seg_out", 32'(seg_out), 32'd0);
      chk("blank_strobe", 32'(sample_strobe), (b == BL) ? 32'd1 : 32'd0);
    end
    for (int s = 0; s < DW; s++) begin
      step();
      chk("show_dig_en", 32'(dig_en), 32'(exp_en));
      chk("show_seg_out", 32'(seg_out), 32'(v.seg));
      chk("show_strobe", 32'(sample_strobe), 32'd0);
      if (v.upd && s == 1) seg_in = v.upd_val;
    end
    $display("visit digit=%0d seg=%02h frame_done=%0d", v.dig, v.seg, v.fd);
    step();
  endtask

  initial begin
    vt[0]  = mk(4'b0000, 0, 8'h11, 1'b0, 1'b0, 32'h0);
    vt[1]  = mk(4'b0000, 1, 8'h22, 1'b0, 1'b0, 32'h0);
    vt[2]  = mk(4'b0000, 2, 8'h33, 1'b0, 1'b0, 32'h0);
    vt[3]  = mk(4'b0000, 3, 8'h44, 1'b0, 1'b0, 32'h0);
    vt[4]  = mk(4'b0000, 0, 8'h11, 1'b1, 1'b1, 32'h443322FF);
    vt[5]  = mk(4'b0000, 1, 8'h22, 1'b0, 1'b0, 32'h0);
    vt[6]  = mk(4'b0000, 2, 8'h33, 1'b0, 1'b0, 32'h0);
    vt[7]  = mk(4'b0000, 3, 8'h44, 1'b0, 1'b0, 32'h0);
    vt[8]  = mk(4'b0000, 0, 8'hFF, 1'b1, 1'b0, 32'h0);
    vt[9]  = mk(4'b0101, 1, 8'h22, 1'b0, 1'b0, 32'h0);
    vt[10] = mk(4'b0101, 3, 8'h44, 1'b0, 1'b0, 32'h0);
    vt[11] = mk(4'b0101, 1, 8'h22, 1'b1, 1'b0, 32'h0);
    vt[12] = mk(4'b0101, 3, 8'h44, 1'b0, 1'b0, 32'h0);
    vt[13] = mk(4'b0101, 1, 8'h22, 1'b1, 1'b0, 32'h0);
    vt[14] = mk(4'b0000, 3, 8'h44, 1'b0, 1'b0, 32'h0);
    vt[15] = mk(4'b0000, 0, 8'hFF, 1'b1, 1'b0, 32'h0);
    vt[16] = mk(4'b1110, 0, 8'hFF, 1'b0, 1'b0, 32'h0);
    vt[17] = mk(4'b1110, 0, 8'hFF, 1'b1, 1'b0, 32'h0);
    vt[18] = mk(4'b1110, 0, 8'hFF, 1'b1, 1'b0, 32'h0);
    vt[19] = mk(4'b0000, 0, 8'h11, 1'b0, 1'b0, 32'h0);
    vt[20] = mk(4'b0000, 1, 8'h22, 1'b0, 1'b0, 32'h0);

    rst = 1'b1; enable = 1'b0; seg_in = 32'h44332211; skip_mask = '0;
    #12;
    chk("rst_seg_out", 32'(seg_out), 32'd0);
    chk("rst_dig_en", 32'(dig_en), 32'd0);
    chk("rst_cur_digit", 32'(cur_digit), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0; enable = 1'b1;
    step();

    // Full rotation, mid-dwell seg_in change, then masked rotation.
    for (int i = 0; i <= 13; i++) visit(vt[i]);

    // Drop enable mid-dwell of digit 2; resume continues at digit 3.
    skip_mask = 4'b0000;
    #1;
    chk("dis_sel_frame_done", 32'(frame_done), 32'd0);
    step();
    chk("dis_cur_digit", 32'(cur_digit), 32'd2);
    step();
    chk("dis_strobe", 32'(sample_strobe), 32'd1);
    step();
    chk("dis_show_dig_en", 32'(dig_en), 32'h4);
    chk("dis_show_seg_out", 32'(seg_out), 32'h33);
    enable = 1'b0;
    step();
    chk("dis_off_dig_en", 32'(dig_en), 32'd0);
    chk("dis_off_seg_out", 32'(seg_out), 32'd0);
    repeat (3) begin
      step();
      chk("dis_idle_dig_en", 32'(dig_en), 32'd0);
      chk("dis_idle_strobe", 32'(sample_strobe), 32'd0);
    end
    enable = 1'b1;
    step();
    visit(vt[14]);
    visit(vt[15]);

    // Everything masked: nothing lit, no strobes.
    skip_mask = 4'b1111;
    #1;
    chk("allmask_sel_frame_done", 32'(frame_done), 32'd0);
    step();
    repeat (6) begin
      chk("allmask_dig_en", 32'(dig_en), 32'd0);
      chk("allmask_seg_out", 32'(seg_out), 32'd0);
      chk("allmask_strobe", 32'(sample_strobe), 32'd0);
      chk("allmask_frame_done", 32'(frame_done), 32'd0);
      step();
    end
    skip_mask = 4'b1110;
    step();
    for (int i = 16; i <= 18; i++) visit(vt[i]);

    // Asynchronous reset mid-BLANK (strobe cycle) and mid-SHOW.
    seg_in = 32'h44332211;
    skip_mask = 4'b0000;
    step();
    step();
    chk("rstb_strobe_before", 32'(sample_strobe), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rstb_strobe", 32'(sample_strobe), 32'd0);
    chk("rstb_dig_en", 32'(dig_en), 32'd0);
    chk("rstb_cur_digit", 32'(cur_digit), 32'd0);
    #2 rst = 1'b0;
    step();
    step();
    chk("rsts_cur_digit", 32'(cur_digit), 32'd0);
    step();
    step();
    chk("rsts_show_dig_en", 32'(dig_en), 32'h1);
    chk("rsts_show_seg_out", 32'(seg_out), 32'h11);
    #3 rst = 1'b1;
    #1;
    chk("rsts_dig_en", 32'(dig_en), 32'd0);
    chk("rsts_seg_out", 32'(seg_out), 32'd0);
    #2 rst = 1'b0;
    step();
    visit(vt[19]);
    visit(vt[20]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_sched.md
# seg_scan_sched

Time-multiplexing scheduler for the shared 7-segment output bus. It lets several snake engines, or other per-digit segment sources, drive one segment bus plus per-digit enables. Unmasked digits are served round-robin, each for a fixed dwell. A blanking gap separates digits to prevent ghosting. It sits between the per-digit segment generators and the `uo_out` / `uio_out` pads.

## Interface
- `NUM_DIGITS`, default 4: number of digit sources, 2..8.
- `DWELL`, default 1024: cycles a digit is lit per visit, ≥1.
- `BLANK`, default 4: blank cycles before each digit, ≥1.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: scan enable.
- `seg_in`  in  NUM_DIGITS*8: packed segment bytes; digit k = `seg_in[8k+7:8k]`; bit 7 = dp.
- `skip_mask`  in  NUM_DIGITS: 1 = digit excluded from scan.
- `seg_out`  out  8: segment bus (registered).
- `dig_en`  out  NUM_DIGITS: one-hot digit enable, or all zero.
- `cur_digit`  out  3: index of digit selected or being shown.
- `sample_strobe`  out  1: 1-cycle pulse; `seg_in` of `cur_digit` is captured this cycle.
- `frame_done`  out  1: 1-cycle pulse on round-robin wrap.

## Operation
- **Reset values:** state IDLE; `seg_out`=0, `dig_en`=0, `cur_digit`=0, `sample_strobe`=0, `frame_done`=0; round-robin pointer "last shown" = NUM_DIGITS-1, so the first pick is digit 0.
- **Reset assertion:** asynchronous; all outputs clear immediately, mid-dwell included.
- **FSM states:** IDLE, SELECT, BLANK, SHOW.
- **IDLE**
  - Outputs zero.
  - Goes to SELECT when `enable`=1 and `skip_mask` is not all ones.
- **SELECT** (1 cycle)
  - Picks the first unmasked index searching circularly from last_shown+1.
  - Writes it to `cur_digit` and last_shown.
  - Loads the counter with BLANK, then goes to BLANK.
  - `skip_mask` is sampled only here.
- **BLANK**
  - `dig_en`=0 and `seg_out`=0; the counter decrements.
  - On the final BLANK cycle: `sample_strobe`=1, `seg_in` byte `cur_digit` is registered into `seg_out`, and the counter is loaded with DWELL.
  - Then goes to SHOW.
- **SHOW**
  - `dig_en[cur_digit]`=1; `seg_out` holds the snapshot, so `seg_in` changes during SHOW have no effect.
  - After DWELL cycles: goes to SELECT if `enable`=1 and some digit is unmasked, else to IDLE.
- **frame_done**
  - Asserted in a SELECT cycle whose chosen index ≤ the previously shown index.
  - Never asserted on the first SELECT after IDLE or reset.
  - With a single unmasked digit it pulses on every visit after the first.
- **enable low**
  - Takes effect at the next edge from any state: go to IDLE, `dig_en`=0, `seg_out`=0.
  - last_shown is retained, so resuming continues round-robin.
- **All digits masked at SELECT:** go to IDLE, no strobe, outputs zero.
- **Mask change mid-SHOW:** the current dwell completes; the change takes effect at the next SELECT.
- **Invariants:** `dig_en` is never more than one-hot; `seg_out` ≠ 0 only while `dig_en` ≠ 0.

## Timing
- **Startup:** `enable` sampled high at edge E:
  - SELECT after E;
  - `cur_digit` valid after E+1;
  - `sample_strobe` high in cycle E+BLANK;
  - `dig_en` rises at edge E+1+BLANK.
- **Steady state:**
  - `dig_en` high exactly DWELL cycles;
  - then low exactly 1+BLANK cycles;
  - period per digit = DWELL+BLANK+1.
- **Pulse timing:** `sample_strobe` precedes `dig_en` rise by 1 cycle; `frame_done` coincides with SELECT.
- **Counters:** width clog2(max(DWELL,BLANK))+1; no wrap possible.
- **Shutdown:** `enable` low at edge F makes outputs 0 after F (1-cycle latency).

## Test plan
- NUM_DIGITS=4, DWELL=4, BLANK=2; `seg_in`=0x44_33_22_11; enable at edge 1:
  - `dig_en` sequence 0001/0010/0100/1000 repeating, each high 4 cycles, low 3;
  - `seg_out` = 0x11/0x22/0x33/0x44 while lit;
  - `frame_done` at each return to digit 0 (not the first).
- `skip_mask`=0101: only digits 1 and 3 served, alternating with 7-cycle period; `frame_done` on each return to digit 1.
- Change `seg_in` byte 0 to 0xFF mid-SHOW of digit 0: `seg_out` stays 0x11 until the next visit, then shows 0xFF.
- `enable` dropped mid-SHOW of digit 2: outputs 0 after one edge; on re-enable the first lit digit is 3.
- `skip_mask`=1111 with enable high: `dig_en`/`seg_out` stay 0, no strobes. Then mask=1110: only digit 0 is lit, and `frame_done` pulses on every visit after the first.
- `rst` asserted asynchronously mid-BLANK and mid-SHOW: all outputs 0 immediately. After release with enable high, the first lit digit is 0.
